lstm_window_feeder: RTL
=======================

# lstm_window_feeder

Sliding-window front end and result collector for the 4-step pipelined LSTM (`lstm_4step_pipeline`, Q6.11, 18-bit). Accepts a stream of daily samples over a valid/ready handshake and keeps the last four. Once the window is full, every new sample launches one window into the pipeline, with x1..x4 skewed one cycle per stage so each stage sees its own day. Captures h4/c4 when they emerge and buffers them in a result FIFO with backpressure, throttling input so no result is ever dropped.

## Interface
- `WIDTH`, 18, sample/state width (signed Q6.11).
- `DEPTH`, 8, result FIFO depth in entries. Minimum 2.
- `clk` input 1: the single clock. All logic is on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `s_valid` input 1: input sample valid.
- `s_ready` output 1: input sample ready.
- `s_data` input WIDTH: input sample (one day).
- `flush` input 1: discards the window contents. In-flight windows are unaffected.
- `x1`, `x2`, `x3`, `x4` output WIDTH each: to the pipeline's x1..x4 inputs.
- `h4_in`, `c4_in` input WIDTH each: from the pipeline's h4_out and c4_out.
- `m_valid` output 1: result valid.
- `m_ready` input 1: result ready.
- `m_h` output WIDTH: buffered h4 result.
- `m_c` output WIDTH: buffered c4 result. Present only with `LSTM_FEEDER_CELL_OUT_EN`.

## Operation
- **Accept:** a sample is accepted on an edge where `s_valid && s_ready`.
- **Window and fill count:**
  - Window registers w0 (oldest) to w3 (newest) shift on every accept.
  - Fill count saturates at 4.
- **Launch:**
  - An accept that makes or keeps the fill count at 4 launches the window {w1, w2, w3, s_data}, i.e. the post-shift contents.
  - At most one launch per cycle, so back-to-back accepts give back-to-back launches.
- **Skew:**
  - Launch slot k (k = 1..4) drives xk with window element k exactly one cycle, in cycle k-1 after the launch edge.
  - Any xk whose slot is idle drives 0.
- **Launch tracking:**
  - A 5-bit valid shift register tracks launches. In-flight count = number of set bits.
  - Bit 4 set means h4_in/c4_in are valid in the current cycle; they are written to the FIFO at that cycle's closing edge.
- **s_ready:**
  - s_ready = !flush && (fill < 3 || inflight + occupancy < DEPTH).
  - The FIFO therefore can never overflow, and the pipeline never stalls.
- **FIFO:**
  - Circular buffer, in order. m_valid = (occupancy != 0); m_h/m_c show the head entry.
  - On a pop (`m_valid && m_ready`), the head advances.
  - A write and a pop on the same edge leave occupancy unchanged; write and read pointers wrap modulo DEPTH.
- **Flush:**
  - Clears the fill count and w0..w3 to 0. s_ready is low during flush.
  - Launch pipeline and FIFO contents are retained.
- **Arithmetic:** no arithmetic is performed on samples; data passes bit-exact.

## Timing
- **Reset values:**
  - x1..x4 = 0, m_h = 0, m_c = 0, m_valid = 0.
  - s_ready = 1 in the first cycle after rst deasserts.
  - Fill count, launch register and FIFO occupancy = 0.
- **Reset mid-operation:** in-flight windows and buffered results are discarded. Pipeline outputs arriving after reset are ignored because the launch bits are clear.
- **Latency, launch edge E0 to outputs:**
  - x1 is valid in cycle 0 (between E0 and E1), x2 in cycle 1, x3 in cycle 2, x4 in cycle 3.
  - h4_in is sampled at E5, the closing edge of cycle 4.
  - m_valid is asserted in cycle 5, i.e. after E5, when the FIFO was empty.
- **Throughput:** one result per cycle when m_ready is held high.
- **Combinational paths:** s_ready depends combinationally on flush and registered state only. m_valid, m_h and m_c are registered/FIFO-read outputs.

## Configuration
- `LSTM_FEEDER_CELL_OUT_EN`
  - **Defined:** the FIFO stores {c4, h4} (2·WIDTH bits per entry), and port `m_c` exists, aligned with `m_h`.
  - **Undefined:** the FIFO is WIDTH bits wide, `c4_in` is ignored, and `m_c` is absent.

## Test plan
- **Reset:** rst for 3 cycles with s_valid=1 and random data -> all outputs 0; no accept; after release, s_ready=1 and m_valid=0.
- **First window:** accept 2048, 4096, 6144, 8192 back-to-back (4th accept = E0), with a pipeline model driving h4_in = x1+x4 -> x1=2048 in cycle 0, x2=4096 in cycle 1, x3=6144 in cycle 2, x4=8192 in cycle 3; m_valid rises in cycle 5 with m_h=10240.
- **Sliding:** continue with 10240 on the next cycle -> second launch one cycle later carrying 4096, 6144, 8192, 10240; results emerge on consecutive cycles, in order.
- **Backpressure:** DEPTH=8, m_ready=0, stream 20 samples -> s_ready falls once inflight+occupancy=8; exactly 8 results are buffered; then m_ready=1 drains all 8 in launch order with no loss or duplication; further 4-sample windows resume.
- **Flush:** accept 2 samples, flush 1 cycle, then accept 3 samples -> no launch; the 4th sample after the flush launches a window containing only post-flush data.
- **Reset mid-flight:** rst asserted 2 cycles after a launch -> m_valid stays 0 and the FIFO is empty; a fresh 4-sample window then behaves as in the first-window scenario.

Source files
------------

// File: rtl/lstm_window_feeder.sv
// rtl/lstm_window_feeder.sv - sliding 4-sample window launcher and in-order result FIFO for the 4-step LSTM pipeline
// Define LSTM_FEEDER_CELL_OUT_EN to buffer c4 alongside h4 and expose m_c.
module lstm_window_feeder #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             flush,
  output logic [WIDTH-1:0] x1,
  output logic [WIDTH-1:0] x2,
  output logic [WIDTH-1:0] x3,
  output logic [WIDTH-1:0] x4,
  input  logic [WIDTH-1:0] h4_in,
  input  logic [WIDTH-1:0] c4_in,
  output logic             m_valid,
  input  logic             m_ready,
`ifdef LSTM_FEEDER_CELL_OUT_EN
  output logic [WIDTH-1:0] m_c,
`endif
  output logic [WIDTH-1:0] m_h
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 4;
`ifdef LSTM_FEEDER_CELL_OUT_EN
  localparam int EW = 2 * WIDTH;
`else
  localparam int EW = WIDTH;
`endif

  logic [3:0][WIDTH-1:0]     w_q, w_d;
  logic [2:0]                fill_q, fill_d;
  logic [4:0]                v_q, v_d;
  logic [WIDTH-1:0]          x1_q, x1_d, x2_q, x2_d, x3_q, x3_d, x4_q, x4_d;
  logic [WIDTH-1:0]          p2_q, p2_d, p3a_q, p3a_d, p3b_q, p3b_d;
  logic [WIDTH-1:0]          p4a_q, p4a_d, p4b_q, p4b_d, p4c_q, p4c_d;
  logic [DEPTH-1:0][EW-1:0]  mem_q, mem_d;
  logic [PW-1:0]             wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]             cnt_q, cnt_d;

  logic [2:0]    inflight;
  logic [SW-1:0] pending;
  logic          accept, launch, push, pop;
  logic [EW-1:0] entry, head;

  // Admission reserves a FIFO slot for every window still in the pipeline.
  always_comb begin
    inflight = 3'(v_q[0]) + 3'(v_q[1]) + 3'(v_q[2]) + 3'(v_q[3]) + 3'(v_q[4]);
    pending  = SW'(inflight) + SW'(cnt_q);
    s_ready  = !flush && ((fill_q < 3'd3) || (pending < SW'(DEPTH)));
    accept   = s_valid && s_ready;
    launch   = accept && (fill_q >= 3'd3);
    push     = v_q[4];
    pop      = m_valid && m_ready;
  end

  always_comb begin
    w_d    = w_q;
    fill_d = fill_q;
    if (flush) begin
      w_d    = '0;
      fill_d = '0;
    end else if (accept) begin
      w_d[0] = w_q[1];
      w_d[1] = w_q[2];
      w_d[2] = w_q[3];
      w_d[3] = s_data;
      if (fill_q != 3'd4) begin
        fill_d = fill_q + 3'd1;
      end
    end
  end

  // Each later element rides extra delay stages so stage k sees its day in cycle k-1.
  always_comb begin
    v_d   = {v_q[3:0], launch};
    x1_d  = launch ? w_q[1] : '0;
    p2_d  = launch ? w_q[2] : '0;
    p3a_d = launch ? w_q[3] : '0;
    p4a_d = launch ? s_data : '0;
    x2_d  = p2_q;
    p3b_d = p3a_q;
    x3_d  = p3b_q;
    p4b_d = p4a_q;
    p4c_d = p4b_q;
    x4_d  = p4c_q;
  end

`ifdef LSTM_FEEDER_CELL_OUT_EN
  assign entry = {c4_in, h4_in};
`else
  logic unused_c4;
  assign unused_c4 = ^c4_in;
  assign entry     = h4_in;
`endif

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wr_q] = entry;
      wr_d        = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1);
    end
    if (pop) begin
      rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1);
    end
    if (push && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q    <= '0;
      fill_q <= '0;
      v_q    <= '0;
      x1_q   <= '0;
      x2_q   <= '0;
      x3_q   <= '0;
      x4_q   <= '0;
      p2_q   <= '0;
      p3a_q  <= '0;
      p3b_q  <= '0;
      p4a_q  <= '0;
      p4b_q  <= '0;
      p4c_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
    end else begin
      w_q    <= w_d;
      fill_q <= fill_d;
      v_q    <= v_d;
      x1_q   <= x1_d;
      x2_q   <= x2_d;
      x3_q   <= x3_d;
      x4_q   <= x4_d;
      p2_q   <= p2_d;
      p3a_q  <= p3a_d;
      p3b_q  <= p3b_d;
      p4a_q  <= p4a_d;
      p4b_q  <= p4b_d;
      p4c_q  <= p4c_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy gates everything read from it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // The oldest sample is shifted out but never launched.
  logic unused_w0;
  assign unused_w0 = ^w_q[0];

  assign x1      = x1_q;
  assign x2      = x2_q;
  assign x3      = x3_q;
  assign x4      = x4_q;
  assign m_valid = (cnt_q != '0);
  assign head    = mem_q[rd_q];
  assign m_h     = m_valid ? head[WIDTH-1:0] : '0;
`ifdef LSTM_FEEDER_CELL_OUT_EN
  assign m_c     = m_valid ? head[EW-1:WIDTH] : '0;
`endif

endmodule
